// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a framed byte stream before the CPU runs.
// Frame: count hi, count lo, count*4 big-endian data bytes, XOR checksum of data bytes.
// The CPU is held in reset while a load is in progress or has failed.
module imem_loader #(
    parameter logic [31:0] ADDR_BASE      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 32'd256,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        we,
    output logic [31:0] waddr,
    output logic [31:0] wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CNT_HI = 3'd1,
        ST_CNT_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_t;

    localparam logic [31:0] MAX_WORDS_C  = MAX_WORDS;
    localparam logic [31:0] TIMEOUT_C    = TIMEOUT_CYCLES;
    localparam bit          TIMEOUT_EN_C = (TIMEOUT_CYCLES != 32'd0);

    // Running checksum: plain XOR of every data byte.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    // States in which the loader is waiting for stream bytes.
    function automatic logic is_rx_state(input state_t st);
        logic rx;
        case (st)
            ST_CNT_HI, ST_CNT_LO, ST_DATA, ST_CSUM: rx = 1'b1;
            default:                               rx = 1'b0;
        endcase
        return rx;
    endfunction

    // Byte address of word idx; wraps modulo 2^32.
    function automatic logic [31:0] word_addr(input logic [15:0] idx);
        return ADDR_BASE + {14'd0, idx, 2'b00};
    endfunction

    state_t       state_r;
    logic [7:0]   cnt_hi_r;
    logic [15:0]  count_r;
    logic [15:0]  word_idx_r;
    logic [1:0]   byte_idx_r;
    logic [23:0]  shift_r;
    logic [7:0]   csum_r;
    logic [31:0]  idle_cnt_r;

    logic         byte_fire_s;
    logic [15:0]  hdr_count_s;
    logic         count_over_s;
    logic         last_word_s;
    logic [31:0]  idle_next_s;
    logic         timeout_hit_s;

    // Ready is a pure decode of the state register.
    assign in_ready = is_rx_state(state_r);

    // Decode of the current transfer, header count and timeout condition.
    always_comb begin
        byte_fire_s   = 1'b0;
        hdr_count_s   = 16'd0;
        count_over_s  = 1'b0;
        last_word_s   = 1'b0;
        idle_next_s   = 32'd0;
        timeout_hit_s = 1'b0;

        byte_fire_s  = in_valid & in_ready;
        hdr_count_s  = {cnt_hi_r, in_data};
        count_over_s = ({16'd0, hdr_count_s} > MAX_WORDS_C);
        last_word_s  = ((word_idx_r + 16'd1) == count_r);
        idle_next_s  = idle_cnt_r + 32'd1;
        if (TIMEOUT_EN_C) begin
            timeout_hit_s = (idle_next_s >= TIMEOUT_C);
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Idle counter: consecutive receiving cycles without an accepted byte.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt_r <= 32'd0;
        end else if (!in_ready || byte_fire_s) begin
            idle_cnt_r <= 32'd0;
        end else begin
            idle_cnt_r <= idle_next_s;
        end
    end

    // Loader FSM with word assembly, write port and status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_hi_r     <= 8'd0;
            count_r      <= 16'd0;
            word_idx_r   <= 16'd0;
            byte_idx_r   <= 2'd0;
            shift_r      <= 24'd0;
            csum_r       <= 8'd0;
            we           <= 1'b0;
            waddr        <= 32'd0;
            wdata        <= 32'd0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'd0;
        end else begin
            // The write strobe is a single-cycle pulse.
            we <= 1'b0;

            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_r      <= ST_CNT_HI;
                        cnt_hi_r     <= 8'd0;
                        count_r      <= 16'd0;
                        word_idx_r   <= 16'd0;
                        byte_idx_r   <= 2'd0;
                        shift_r      <= 24'd0;
                        csum_r       <= 8'd0;
                        words_loaded <= 16'd0;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end

                ST_CNT_HI: begin
                    if (byte_fire_s) begin
                        cnt_hi_r <= in_data;
                        state_r  <= ST_CNT_LO;
                    end else if (timeout_hit_s) begin
                        state_r <= ST_ERR;
                        error   <= 1'b1;
                    end else begin
                        state_r <= ST_CNT_HI;
                    end
                end

                ST_CNT_LO: begin
                    if (byte_fire_s) begin
                        count_r <= hdr_count_s;
                        if (count_over_s) begin
                            state_r <= ST_ERR;
                            error   <= 1'b1;
                        end else if (hdr_count_s == 16'd0) begin
                            state_r <= ST_CSUM;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else if (timeout_hit_s) begin
                        state_r <= ST_ERR;
                        error   <= 1'b1;
                    end else begin
                        state_r <= ST_CNT_LO;
                    end
                end

                ST_DATA: begin
                    if (byte_fire_s) begin
                        csum_r <= csum_update(csum_r, in_data);
                        if (byte_idx_r == 2'd3) begin
                            // Fourth byte: issue the write one cycle behind the stream.
                            we           <= 1'b1;
                            waddr        <= word_addr(word_idx_r);
                            wdata        <= {shift_r, in_data};
                            words_loaded <= words_loaded + 16'd1;
                            word_idx_r   <= word_idx_r + 16'd1;
                            byte_idx_r   <= 2'd0;
                            if (last_word_s) begin
                                state_r <= ST_CSUM;
                            end else begin
                                state_r <= ST_DATA;
                            end
                        end else begin
                            shift_r    <= {shift_r[15:0], in_data};
                            byte_idx_r <= byte_idx_r + 2'd1;
                        end
                    end else if (timeout_hit_s) begin
                        state_r <= ST_ERR;
                        error   <= 1'b1;
                    end else begin
                        state_r <= ST_DATA;
                    end
                end

                ST_CSUM: begin
                    if (byte_fire_s) begin
                        if (in_data == csum_r) begin
                            state_r  <= ST_DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state_r <= ST_ERR;
                            error   <= 1'b1;
                        end
                    end else if (timeout_hit_s) begin
                        state_r <= ST_ERR;
                        error   <= 1'b1;
                    end else begin
                        state_r <= ST_CSUM;
                    end
                end

                default: begin
                    state_r  <= ST_ERR;
                    error    <= 1'b1;
                    cpu_hold <= 1'b1;
                end
            endcase
        end
    end

endmodule
